friscv_cache_line_loader: RTL and testbench
===========================================

# friscv_cache_line_loader

Memory-side loader of the instruction cache: accepts one cache-line read request from the prefetcher sequencer, issues a single-beat AXI4 read to central memory, and writes the returned block into the cache lines. Sits between the prefetcher (request source, consumer of `cache_writing`) and the AXI4 read channels of the central memory. Handles one transaction at a time, discards stray beats, and never leaves the prefetcher waiting forever: every accepted request ends with exactly one `cache_writing` pulse, even on error or timeout.

## Interface
- `AXI_ADDR_W`, 32, AXI4 address width
- `AXI_ID_W`, 8, AXI4 ID width
- `AXI_DATA_W`, 128, AXI4 data width, equal to the cache block width
- `TIMEOUT`, 1024, max cycles waiting for the R beat; 0 disables the timeout
- `aclk`  in  1  clock; one clock, everything on its rising edge
- `aresetn`  in  1  asynchronous active-low reset
- `srst`  in  1  synchronous active-high reset, same effect as `aresetn`
- `memctrl_arvalid`  in  1  request valid from the prefetcher
- `memctrl_arready`  out  1  request accepted
- `memctrl_araddr`  in  AXI_ADDR_W  line address
- `memctrl_arprot`  in  3  protection
- `memctrl_arid`  in  AXI_ID_W  transaction ID
- `mst_arvalid`/`mst_arready`  out/in  1  AXI4 AR handshake
- `mst_araddr`  out  AXI_ADDR_W;  `mst_arlen` out 8;  `mst_arsize` out 3;  `mst_arburst` out 2;  `mst_arlock` out 1;  `mst_arcache` out 4;  `mst_arprot` out 3;  `mst_arid` out AXI_ID_W
- `mst_rvalid`/`mst_rready`  in/out  1  AXI4 R handshake
- `mst_rid`  in  AXI_ID_W;  `mst_rresp` in 2;  `mst_rdata` in AXI_DATA_W;  `mst_rlast` in 1
- `cache_writing`  out  1  loader completion pulse for the prefetcher
- `cache_wen`  out  1  cache line write enable
- `cache_waddr`  out  AXI_ADDR_W  line address to write
- `cache_wdata`  out  AXI_DATA_W  block to write
- `rd_error`  out  1  one-cycle pulse on a bad response or a timeout

## Operation
- **Constants:**
  - `mst_arlen`=0; `mst_arsize`=$clog2(AXI_DATA_W/8); `mst_arburst`=2'b01; `mst_arlock`=0; `mst_arcache`=4'b0000.
  - `mst_araddr` low $clog2(AXI_DATA_W/8) bits are forced to 0.
- **FSM states:** IDLE, ADDR, DATA, WRITE.
- **IDLE:**
  - `memctrl_arready`=1, decoded combinationally from the state only.
  - On `memctrl_arvalid`, register the aligned address, id and prot, set `mst_arvalid`, go to ADDR.
- **ADDR:**
  - Hold `mst_arvalid` and the AR fields stable until `mst_arready`.
  - On the handshake, drop `mst_arvalid`, clear the timeout counter, go to DATA.
- **DATA:** `mst_rready`=1.
  - Beat with `mst_rid` ≠ the stored ID: consumed and discarded, state unchanged.
  - Matching beat with `rresp`=OKAY (2'b00): register `rdata`, go to WRITE with `ok`=1.
  - Matching beat with `rresp`≠OKAY: go to WRITE with `ok`=0.
  - `mst_rlast` is ignored.
  - Timeout counter, width $clog2(TIMEOUT+1), increments each DATA cycle. When it reaches TIMEOUT (TIMEOUT>0), go to WRITE with `ok`=0.
- **WRITE:** lasts exactly one cycle, then IDLE.
  - `cache_writing`=1 in all cases.
  - `cache_wen`=`ok`; `cache_waddr`/`cache_wdata` are valid when `cache_wen`=1.
  - `rd_error`=!`ok`.
- **Reset values:** all registered outputs are 0 and the state is IDLE. `memctrl_arready` is therefore 1 out of reset.
- **Reset mid-transaction:** `aresetn` or `srst` aborts the transaction. No `cache_writing` pulse is produced, and any later R beat for it is discarded as stray.

## Timing
- **Request to AXI:** request handshake at cycle T → `mst_arvalid`=1 at T+1.
- **AR stall:** AR handshake at cycle A ≥ T+1 → `mst_arvalid`=0 and `mst_rready`=1 at A+1.
- **Completion:** R beat accepted at cycle R → `cache_writing`/`cache_wen` high during R+1 only, `memctrl_arready`=1 again at R+2.
- **Best case:** `mst_arready` already high, `rvalid` one cycle after AR → request-to-write latency is 3 cycles, back-to-back request throughput one per 4 cycles.
- **Timeout:** DATA entered at cycle D with no matching beat → WRITE at D+TIMEOUT with `cache_wen`=0, `rd_error`=1.
- **Simultaneous events:**
  - A beat arriving on the same cycle the timeout fires is accepted as the completion; the beat wins.
  - `mst_rvalid` outside DATA is not acknowledged (`mst_rready`=0).

## Test plan
- **Nominal read:** `memctrl_araddr`=0x1234, id=5, `mst_arready`=1, `rvalid` with rid=5, `rdata`=D at +1 → `mst_araddr`=0x1230 (AXI_DATA_W=128), `arsize`=4. `cache_wen`=1 with `waddr`=0x1230 and `wdata`=D, `cache_writing` one cycle, `memctrl_arready` back 2 cycles after R.
- **AR backpressure:** `mst_arready` low for 7 cycles → `mst_arvalid` and `mst_araddr` stable throughout. Single AR handshake, no R acceptance before it.
- **Stray beat:** rid=3 beat, then rid=5 beat with data E → first discarded with no write. `cache_wdata`=E, exactly one `cache_writing` pulse.
- **Error response:** `rresp`=2'b10 → `cache_writing`=1, `cache_wen`=0, `rd_error`=1 in the same cycle. IDLE next cycle.
- **Timeout:** TIMEOUT=16, no R beat → WRITE exactly 16 cycles after DATA entry with `rd_error`=1, `cache_wen`=0. A late beat afterwards is not acknowledged while IDLE.
- **Reset:** `aresetn` low during DATA → all outputs 0, `memctrl_arready`=1 after release, no `cache_writing` pulse.

Source files
------------

// File: rtl/friscv_cache_line_loader_if.sv
// friscv_cache_line_loader_if: AXI4 read address and read data channels between the loader and central memory
interface friscv_cache_line_loader_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W = 8,
  parameter int AXI_DATA_W = 128
);
  logic arvalid;
  logic arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arlock;
  logic [3:0] arcache;
  logic [2:0] arprot;
  logic [AXI_ID_W-1:0] arid;
  logic rvalid;
  logic rready;
  logic [AXI_ID_W-1:0] rid;
  logic [1:0] rresp;
  logic [AXI_DATA_W-1:0] rdata;
  logic rlast;
  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid, rready,
    input arready, rvalid, rid, rresp, rdata, rlast
  );
  modport slave (
    input arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arid, rready,
    output arready, rvalid, rid, rresp, rdata, rlast
  );
endinterface

// File: rtl/friscv_cache_line_loader.sv
// friscv_cache_line_loader: fetches one cache block per prefetcher request over AXI4 and writes it into the cache
module friscv_cache_line_loader #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W = 8,
  parameter int AXI_DATA_W = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic srst,
  input  logic memctrl_arvalid,
  output logic memctrl_arready,
  input  logic [AXI_ADDR_W-1:0] memctrl_araddr,
  input  logic [2:0] memctrl_arprot,
  input  logic [AXI_ID_W-1:0] memctrl_arid,
  friscv_cache_line_loader_if.master mst,
  output logic cache_writing,
  output logic cache_wen,
  output logic [AXI_ADDR_W-1:0] cache_waddr,
  output logic [AXI_DATA_W-1:0] cache_wdata,
  output logic rd_error
);
  localparam int OFS = $clog2(AXI_DATA_W/8);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT+1) : 1;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WRITE} state_t;
  state_t state, nxt;
  logic [AXI_ADDR_W-1:0] addr_r;
  logic [AXI_ID_W-1:0] id_r;
  logic [2:0] prot_r;
  logic [AXI_DATA_W-1:0] data_r;
  logic [TW-1:0] cnt;
  logic ok_r;
  logic hit;
  logic tmo;
  assign hit = state == DATA && mst.rvalid && mst.rid == id_r;
  assign tmo = TIMEOUT != 0 && 32'(cnt) == TIMEOUT - 1;
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (memctrl_arvalid ? ADDR : IDLE) :
          state == ADDR ? (mst.arready ? DATA : ADDR) :
          state == DATA ? (hit || tmo ? WRITE : DATA) : IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      addr_r <= '0;
      id_r <= '0;
      prot_r <= '0;
      data_r <= '0;
      cnt <= '0;
      ok_r <= 1'b0;
    end else if (srst) begin
      state <= IDLE;
      addr_r <= '0;
      id_r <= '0;
      prot_r <= '0;
      data_r <= '0;
      cnt <= '0;
      ok_r <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && memctrl_arvalid) begin
        addr_r <= {memctrl_araddr[AXI_ADDR_W-1:OFS], {OFS{1'b0}}};
        id_r <= memctrl_arid;
        prot_r <= memctrl_arprot;
      end
      if (state == ADDR && mst.arready) cnt <= '0;
      if (state == DATA) cnt <= cnt + TW'(1);
      // a matching beat wins over a timeout firing in the same cycle
      if (hit) begin
        ok_r <= mst.rresp == 2'b00;
        if (mst.rresp == 2'b00) data_r <= mst.rdata;
      end else if (state == DATA && tmo) ok_r <= 1'b0;
    end
  end
  assign memctrl_arready = state == IDLE;
  assign mst.arvalid = state == ADDR;
  assign mst.araddr = addr_r;
  assign mst.arlen = 8'd0;
  assign mst.arsize = 3'(OFS);
  assign mst.arburst = 2'b01;
  assign mst.arlock = 1'b0;
  assign mst.arcache = 4'b0000;
  assign mst.arprot = prot_r;
  assign mst.arid = id_r;
  assign mst.rready = state == DATA;
  assign cache_writing = state == WRITE;
  assign cache_wen = state == WRITE && ok_r;
  assign rd_error = state == WRITE && !ok_r;
  assign cache_waddr = addr_r;
  assign cache_wdata = data_r;
endmodule

// File: tb/tb_friscv_cache_line_loader.sv
// tb_friscv_cache_line_loader: directed checks of request, AXI handshakes, stray beats, errors, timeout and resets
module tb_friscv_cache_line_loader;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic srst = 1'b0;
  logic memctrl_arvalid = 1'b0;
  logic memctrl_arready;
  logic [31:0] memctrl_araddr = '0;
  logic [2:0] memctrl_arprot = '0;
  logic [7:0] memctrl_arid = '0;
  logic cache_writing;
  logic cache_wen;
  logic [31:0] cache_waddr;
  logic [127:0] cache_wdata;
  logic rd_error;
  int errors = 0;
  int checks = 0;
  friscv_cache_line_loader_if #(.AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(128)) mst ();
  friscv_cache_line_loader #(.AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(128), .TIMEOUT(16)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .srst(srst),
    .memctrl_arvalid(memctrl_arvalid),
    .memctrl_arready(memctrl_arready),
    .memctrl_araddr(memctrl_araddr),
    .memctrl_arprot(memctrl_arprot),
    .memctrl_arid(memctrl_arid),
    .mst(mst.master),
    .cache_writing(cache_writing),
    .cache_wen(cache_wen),
    .cache_waddr(cache_waddr),
    .cache_wdata(cache_wdata),
    .rd_error(rd_error)
  );
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge aclk);
  endtask
  task automatic issue(input logic [31:0] a, input logic [7:0] id);
    memctrl_araddr = a;
    memctrl_arid = id;
    memctrl_arprot = 3'd3;
    memctrl_arvalid = 1'b1;
    check("req_ready", 128'(memctrl_arready), 128'(1));
    step();
    memctrl_arvalid = 1'b0;
  endtask
  task automatic beat(input logic [7:0] id, input logic [1:0] resp, input logic [127:0] d);
    mst.rvalid = 1'b1;
    mst.rid = id;
    mst.rresp = resp;
    mst.rdata = d;
    step();
    mst.rvalid = 1'b0;
  endtask
  initial begin
    mst.arready = 1'b0;
    mst.rvalid = 1'b0;
    mst.rid = '0;
    mst.rresp = '0;
    mst.rdata = '0;
    mst.rlast = 1'b1;
    step();
    step();
    check("rst_arready", 128'(memctrl_arready), 128'(1));
    check("rst_arvalid", 128'(mst.arvalid), 128'(0));
    check("rst_writing", 128'(cache_writing), 128'(0));
    check("rst_wen", 128'(cache_wen), 128'(0));
    check("rst_err", 128'(rd_error), 128'(0));
    check("rst_waddr", 128'(cache_waddr), 128'(0));
    aresetn = 1'b1;
    step();
    // nominal read
    mst.arready = 1'b1;
    issue(32'h1234, 8'd5);
    check("nom_arvalid", 128'(mst.arvalid), 128'(1));
    check("nom_araddr", 128'(mst.araddr), 128'h1230);
    check("nom_arsize", 128'(mst.arsize), 128'(4));
    check("nom_arlen", 128'(mst.arlen), 128'(0));
    check("nom_arburst", 128'(mst.arburst), 128'(1));
    check("nom_arid", 128'(mst.arid), 128'(5));
    check("nom_arprot", 128'(mst.arprot), 128'(3));
    check("nom_ready_busy", 128'(memctrl_arready), 128'(0));
    step();
    check("nom_arvalid_drop", 128'(mst.arvalid), 128'(0));
    check("nom_rready", 128'(mst.rready), 128'(1));
    beat(8'd5, 2'b00, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
    check("nom_writing", 128'(cache_writing), 128'(1));
    check("nom_wen", 128'(cache_wen), 128'(1));
    check("nom_waddr", 128'(cache_waddr), 128'h1230);
    check("nom_wdata", cache_wdata, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
    check("nom_err", 128'(rd_error), 128'(0));
    check("nom_ready_w", 128'(memctrl_arready), 128'(0));
    step();
    check("nom_writing_end", 128'(cache_writing), 128'(0));
    check("nom_ready_back", 128'(memctrl_arready), 128'(1));
    // AR backpressure with an early R beat that must not be taken
    mst.arready = 1'b0;
    issue(32'h2008, 8'd7);
    mst.rvalid = 1'b1;
    mst.rid = 8'd7;
    for (int i = 0; i < 7; i++) begin
      check("bp_arvalid", 128'(mst.arvalid), 128'(1));
      check("bp_araddr", 128'(mst.araddr), 128'h2000);
      check("bp_rready", 128'(mst.rready), 128'(0));
      step();
    end
    mst.rvalid = 1'b0;
    mst.arready = 1'b1;
    step();
    mst.arready = 1'b0;
    check("bp_arvalid_drop", 128'(mst.arvalid), 128'(0));
    check("bp_rready", 128'(mst.rready), 128'(1));
    beat(8'd7, 2'b00, 128'h77);
    check("bp_wen", 128'(cache_wen), 128'(1));
    check("bp_wdata", cache_wdata, 128'h77);
    step();
    // stray beat then matching beat
    mst.arready = 1'b1;
    issue(32'h3000, 8'd5);
    step();
    beat(8'd3, 2'b00, 128'hbad);
    check("stray_writing", 128'(cache_writing), 128'(0));
    check("stray_rready", 128'(mst.rready), 128'(1));
    beat(8'd5, 2'b00, 128'hEEEE);
    check("stray_writing2", 128'(cache_writing), 128'(1));
    check("stray_wdata", cache_wdata, 128'hEEEE);
    step();
    check("stray_one_pulse", 128'(cache_writing), 128'(0));
    // error response
    issue(32'h4000, 8'd9);
    step();
    beat(8'd9, 2'b10, 128'h1);
    check("err_writing", 128'(cache_writing), 128'(1));
    check("err_wen", 128'(cache_wen), 128'(0));
    check("err_flag", 128'(rd_error), 128'(1));
    step();
    check("err_idle", 128'(memctrl_arready), 128'(1));
    check("err_flag_end", 128'(rd_error), 128'(0));
    // timeout: WRITE 16 cycles after DATA entry
    issue(32'h5000, 8'd1);
    step();
    for (int i = 0; i < 16; i++) begin
      check("tmo_wait", 128'({mst.rready, cache_writing}), 128'(2));
      step();
    end
    check("tmo_writing", 128'(cache_writing), 128'(1));
    check("tmo_err", 128'(rd_error), 128'(1));
    check("tmo_wen", 128'(cache_wen), 128'(0));
    mst.rvalid = 1'b1;
    mst.rid = 8'd1;
    step();
    check("tmo_late_rready", 128'(mst.rready), 128'(0));
    step();
    mst.rvalid = 1'b0;
    check("tmo_late_write", 128'(cache_writing), 128'(0));
    // beat on the timeout cycle wins
    issue(32'h6000, 8'd4);
    step();
    for (int i = 0; i < 15; i++) step();
    beat(8'd4, 2'b00, 128'hF00D);
    check("race_wen", 128'(cache_wen), 128'(1));
    check("race_err", 128'(rd_error), 128'(0));
    check("race_wdata", cache_wdata, 128'hF00D);
    step();
    // async reset during DATA
    issue(32'h7000, 8'd2);
    step();
    aresetn = 1'b0;
    #1;
    check("arst_ready", 128'(memctrl_arready), 128'(1));
    check("arst_rready", 128'(mst.rready), 128'(0));
    check("arst_waddr", 128'(cache_waddr), 128'(0));
    step();
    aresetn = 1'b1;
    mst.rvalid = 1'b1;
    mst.rid = 8'd2;
    check("arst_stray_rready", 128'(mst.rready), 128'(0));
    step();
    mst.rvalid = 1'b0;
    check("arst_no_write", 128'(cache_writing), 128'(0));
    // sync reset during DATA
    issue(32'h8000, 8'd6);
    step();
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("srst_ready", 128'(memctrl_arready), 128'(1));
    check("srst_rready", 128'(mst.rready), 128'(0));
    step();
    check("srst_no_write", 128'(cache_writing), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
